// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised presettable up/down modulo counter with ENT/RCO cascading
module mod_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_dn_next;
  logic             w_count_en;
  logic             w_at_term;

  assign w_count_en = ENP & ENT;

  // ">=" rather than "==" so a loaded out-of-range value falls back to 0 when counting up
  assign w_up_next = (r_q >= TERM_UP) ? '0 : r_q + WIDTH'(1);
  assign w_dn_next = (r_q == '0) ? TERM_UP : r_q - WIDTH'(1);

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_q <= '0;
    end else if (!LOAD) begin
      r_q <= D;
    end else if (w_count_en) begin
      r_q <= UP ? w_up_next : w_dn_next;
    end
  end

  assign w_at_term = UP ? (r_q == TERM_UP) : (r_q == '0);
  assign RCO       = ENT & w_at_term;
  assign Q         = r_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter (mod-10 and 2-stage cascade)
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       clr_n, enp, up;
  logic       load10, ent10;
  logic [3:0] d10, q10;
  logic       rco10;
  logic       load_c, ent0;
  logic [3:0] d0, d1, q0, q1;
  logic       rco0, rco1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .CLK(clk), .CLR(clr_n), .LOAD(load10), .ENP(enp), .ENT(ent10), .UP(up),
    .D(d10), .Q(q10), .RCO(rco10)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16)) u_stage0 (
    .CLK(clk), .CLR(clr_n), .LOAD(load_c), .ENP(enp), .ENT(ent0), .UP(up),
    .D(d0), .Q(q0), .RCO(rco0)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16)) u_stage1 (
    .CLK(clk), .CLR(clr_n), .LOAD(load_c), .ENP(enp), .ENT(rco0), .UP(up),
    .D(d1), .Q(q1), .RCO(rco1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0; enp = 1'b1; up = 1'b1;
    load10 = 1'b1; ent10 = 1'b1; d10 = 4'd0;
    load_c = 1'b1; ent0 = 1'b1; d0 = 4'd0; d1 = 4'd0;
    tick();
    check("reset_q10", int'(q10), 0);
    check("reset_q0", int'(q0), 0);
    check("reset_q1", int'(q1), 0);

    // hold with ENP low
    clr_n = 1'b1; enp = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("hold_q0", int'(q0), 0);
    check("hold_q10", int'(q10), 0);
    check("hold_rco_up", int'(rco0), 0);
    up = 1'b0; #1;
    check("hold_rco_down", int'(rco0), 1);
    ent0 = 1'b0; #1;
    check("ent0_forces_rco_low", int'(rco0), 0);

    // up count, modulus 10
    up = 1'b1; enp = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("up_q_%0d", i), int'(q10), (i + 1) % 10);
      check($sformatf("up_rco_%0d", i), int'(rco10), ((i + 1) % 10 == 9) ? 1 : 0);
    end

    // reset, then down count from 0
    clr_n = 1'b0; tick();
    clr_n = 1'b1; up = 1'b0; #1;
    check("down_start_q", int'(q10), 0);
    check("down_rco_at_0", int'(rco10), 1);
    tick(); check("down_q_9", int'(q10), 9); check("down_rco_9", int'(rco10), 0);
    tick(); check("down_q_8", int'(q10), 8);
    tick(); check("down_q_7", int'(q10), 7); check("down_rco_7", int'(rco10), 0);

    // ENT low freezes even with ENP high
    ent10 = 1'b0; tick();
    check("ent_freeze_q", int'(q10), 7);
    ent10 = 1'b1;

    // load out-of-range with enables high, then up wraps to 0
    up = 1'b1; d10 = 4'd13; load10 = 1'b0; tick();
    check("load_13", int'(q10), 13);
    check("load_13_rco", int'(rco10), 0);
    load10 = 1'b1; tick();
    check("oor_up_to_0", int'(q10), 0);

    // out-of-range down decrements normally
    load10 = 1'b0; tick();
    load10 = 1'b1; up = 1'b0; tick();
    check("oor_down_12", int'(q10), 12);

    // reset beats load
    up = 1'b1; clr_n = 1'b0; load10 = 1'b0; d10 = 4'd5; tick();
    check("clr_beats_load", int'(q10), 0);
    load10 = 1'b1; clr_n = 1'b1;

    // mid-count reset
    for (int i = 0; i < 6; i++) tick();
    check("mid_q_6", int'(q10), 6);
    clr_n = 1'b0; tick();
    check("mid_clr_q", int'(q10), 0);
    clr_n = 1'b1; tick();
    check("mid_resume_q", int'(q10), 1);

    // two-stage binary cascade from 0x0E
    d0 = 4'hE; d1 = 4'h0; load_c = 1'b0; ent0 = 1'b1; tick();
    load_c = 1'b1;
    check("casc_load", int'({q1, q0}), 8'h0E);
    tick();
    check("casc_0f", int'({q1, q0}), 8'h0F);
    check("casc_rco0_0f", int'(rco0), 1);
    check("casc_rco1_0f", int'(rco1), 0);
    tick();
    check("casc_10", int'({q1, q0}), 8'h10);
    check("casc_rco1_10", int'(rco1), 0);
    tick();
    check("casc_11", int'({q1, q0}), 8'h11);
    check("casc_rco1_11", int'(rco1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous presettable counter, the generalised successor to the team's 4-bit 74163-style counter. It adds configurable width and modulus, parallel load, up/down direction and a ripple-carry output (RCO) for cascading. It is a building block for lab datapaths: dividers, timers and address generators. Several instances chain through ENT/RCO into one wide counter.

## Interface
- WIDTH, default 4: counter width in bits, 2..32.
- MODULUS, default 2**WIDTH: count sequence length, 2..2**WIDTH. Terminal value is MODULUS-1 when counting up and 0 when counting down.

- CLK  input  1  rising-edge clock; the only clock.
- CLR  input  1  synchronous, active-low reset. Sampled on the CLK rising edge only.
- LOAD  input  1  synchronous, active-low parallel load.
- ENP  input  1  count enable (parallel), active-high.
- ENT  input  1  count enable (trickle), active-high; also gates RCO.
- UP  input  1  direction: 1 = up, 0 = down.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  registered count.
- RCO  output  1  combinational ripple carry: ENT & (Q == terminal value for current UP).

## Operation
- One WIDTH-bit state register Q. All updates happen on the CLK rising edge. Priority, highest first:
  1. CLR == 0: Q <= 0. This overrides LOAD, ENP and ENT.
  2. LOAD == 0: Q <= D, regardless of ENP/ENT/UP. D is loaded unmodified, including values >= MODULUS.
  3. ENP & ENT & UP: if Q >= MODULUS-1, Q <= 0; otherwise Q <= Q+1.
  4. ENP & ENT & ~UP: if Q == 0, Q <= MODULUS-1; otherwise Q <= Q-1.
  5. Otherwise Q holds.
- Out-of-range Q (>= MODULUS, reachable only via LOAD):
  - Up: returns to 0 on the next enabled edge.
  - Down: decrements normally until it re-enters range.
- Arithmetic is WIDTH bits, unsigned. With MODULUS == 2**WIDTH, wrap is natural overflow (all-ones <-> 0).
- RCO is combinational from registered Q, ENT and UP. It does not depend on ENP, LOAD or CLR.
  - Up: RCO = ENT & (Q == MODULUS-1).
  - Down: RCO = ENT & (Q == 0).
  - An out-of-range Q never asserts RCO.
- Cascading: stage k's RCO drives stage k+1's ENT. ENP, CLK, CLR and UP are shared. For a binary cascade, every stage uses MODULUS = 2**WIDTH.
- No internal FSM beyond the count register. Direction changes take effect on the same edge UP is sampled.

## Timing
- Reset value: Q = 0, and so RCO = ENT & ~UP... evaluated combinationally after reset (RCO = ENT when UP = 0, since Q = 0 is the down terminal).
- Before the first CLR edge, Q is unspecified. The bench must apply CLR = 0 for at least one edge.
- Latency: one cycle from a sampled control to the new Q. RCO follows Q and ENT/UP with zero cycles (combinational).
- CLR = 0 mid-count: Q is 0 after that edge. The count resumes from 0 on the first edge with CLR = 1 and enables high.
- CLR = 0 and LOAD = 0 on the same edge: reset wins.
- LOAD = 0 and enables high on the same edge: load wins, with no increment.
- ENT = 0 freezes Q and forces RCO = 0, whatever ENP is. ENP = 0 freezes Q but leaves RCO live.
- Inputs must be stable for setup/hold around the CLK rising edge. No other timing constraints.

## Test plan
- Reset/hold (WIDTH=4, MODULUS=16): CLR=0 with enables high for 1 edge -> Q=0. Then CLR=1, ENP=0, ENT=1, 5 edges -> Q stays 0. RCO=0 with UP=1 and RCO=1 with UP=0.
- Up count with wrap (WIDTH=4, MODULUS=10): ENP=ENT=UP=1, 12 edges from reset -> Q = 1..9,0,1,2. RCO is high exactly while Q=9.
- Down count with wrap (WIDTH=4, MODULUS=10): UP=0 from Q=0, 3 edges -> Q = 9,8,7. RCO is high only while Q=0.
- Load and priority: D=13, LOAD=0 with enables high -> Q=13 (out of range). Next edge up -> Q=0. CLR=0 and LOAD=0 together with D=5 -> Q=0.
- Cascade: two WIDTH=4 stages (RCO0->ENT1), full modulus, count from 0x0E for 3 edges -> {Q1,Q0} = 0x0F, 0x10, 0x11. Stage-1 RCO stays 0 throughout.
- Mid-count reset: count up to Q=6, then CLR=0 for 1 edge -> Q=0. Next enabled edge -> Q=1.
